// File: rtl/osc_mon_pkg.sv
// rtl/osc_mon_pkg.sv - shared types, defaults and helpers for the oscillator monitor
package osc_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_CHECK   = 2'd2
    } osc_mon_state_e;

    localparam int DEF_WIN_CYCLES   = 5000;
    localparam int DEF_MIN_EDGES    = 90;
    localparam int DEF_MAX_EDGES    = 110;
    localparam int DEF_GOOD_WINDOWS = 4;

    // Increment an 8-bit count by one when inc is set, sticking at 255.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v, input logic inc);
        return (inc && (v != 8'hFF)) ? v + 8'd1 : v;
    endfunction

endpackage

// File: rtl/osc_mon_sync.sv
// rtl/osc_mon_sync.sv - two-flop synchronizer for the reference oscillator
module osc_mon_sync (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops; the first may go metastable, the second resolves it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/osc_clk_monitor.sv
// rtl/osc_clk_monitor.sv - counts reference clock edges per fabric-clock window and flags ratio faults
module osc_clk_monitor
    import osc_mon_pkg::*;
#(
    parameter int WIN_CYCLES   = DEF_WIN_CYCLES,
    parameter int MIN_EDGES    = DEF_MIN_EDGES,
    parameter int MAX_EDGES    = DEF_MAX_EDGES,
    parameter int GOOD_WINDOWS = DEF_GOOD_WINDOWS
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       ref_clk_in,
    input  logic       enable,
    output logic       meas_valid,
    output logic [7:0] edge_count,
    output logic       osc_ok,
    output logic       osc_fail
);

    osc_mon_state_e state;
    osc_mon_state_e state_next;

    logic        ref_sync;
    logic        ref_hist;
    logic        ref_rise;
    logic [15:0] win_cnt;
    logic [7:0]  edge_cnt;
    logic [7:0]  edge_inc;
    logic [3:0]  good_cnt;
    logic [3:0]  good_inc;
    logic        win_last;
    logic        in_range;

    osc_mon_sync u_sync (
        .clk  (clk),
        .rstn (rstn),
        .d    (ref_clk_in),
        .q    (ref_sync)
    );

    assign ref_rise = ref_sync & ~ref_hist;
    assign edge_inc = sat_inc8(edge_cnt, ref_rise);
    assign win_last = (win_cnt == 16'(WIN_CYCLES - 1));
    // edge_count already holds the finished window's count during CHECK.
    assign in_range = (edge_count >= 8'(MIN_EDGES)) && (edge_count <= 8'(MAX_EDGES));
    assign good_inc = (good_cnt == 4'(GOOD_WINDOWS)) ? good_cnt : good_cnt + 4'd1;

    // History flop for rising-edge detection; runs whether or not the monitor is enabled.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ref_hist <= 1'b0;
        end else begin
            ref_hist <= ref_sync;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; dropping enable always wins and returns to IDLE.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (enable) state_next = ST_MEASURE;
            ST_MEASURE: if (win_last) state_next = ST_CHECK;
            ST_CHECK:   state_next = ST_MEASURE;
            default:    state_next = ST_IDLE;
        endcase
        if (!enable) begin
            state_next = ST_IDLE;
        end
    end

    // Window/edge/good counters and the registered status outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            win_cnt    <= 16'd0;
            edge_cnt   <= 8'd0;
            good_cnt   <= 4'd0;
            meas_valid <= 1'b0;
            edge_count <= 8'd0;
            osc_ok     <= 1'b0;
            osc_fail   <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            if (!enable) begin
                win_cnt  <= 16'd0;
                edge_cnt <= 8'd0;
                good_cnt <= 4'd0;
                osc_ok   <= 1'b0;
                osc_fail <= 1'b0;
            end else begin
                case (state)
                    ST_MEASURE: begin
                        if (win_last) begin
                            // Publish with meas_valid so the count is visible on the CHECK cycle.
                            win_cnt    <= 16'd0;
                            edge_cnt   <= 8'd0;
                            edge_count <= edge_inc;
                            meas_valid <= 1'b1;
                        end else begin
                            win_cnt  <= win_cnt + 16'd1;
                            edge_cnt <= edge_inc;
                        end
                    end
                    ST_CHECK: begin
                        // An edge seen on the CHECK cycle belongs to the next window.
                        win_cnt  <= 16'd0;
                        edge_cnt <= {7'd0, ref_rise};
                        if (in_range) begin
                            good_cnt <= good_inc;
                            if (good_inc == 4'(GOOD_WINDOWS)) begin
                                osc_ok <= 1'b1;
                            end
                        end else begin
                            good_cnt <= 4'd0;
                            osc_ok   <= 1'b0;
                            osc_fail <= 1'b1;
                        end
                    end
                    default: begin
                        win_cnt  <= 16'd0;
                        edge_cnt <= 8'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_osc_clk_monitor.sv
// tb/tb_osc_clk_monitor.sv - scoreboard bench for osc_clk_monitor with randomized reference rates
module tb_osc_clk_monitor;

    localparam int WIN   = 1000;
    localparam int MINE  = 90;
    localparam int MAXE  = 110;
    localparam int GOOD  = 4;
    localparam int TCLK  = 20;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       ref_clk_in = 1'b0;
    logic       enable = 1'b0;
    logic       meas_valid;
    logic [7:0] edge_count;
    logic       osc_ok;
    logic       osc_fail;

    osc_clk_monitor #(
        .WIN_CYCLES   (WIN),
        .MIN_EDGES    (MINE),
        .MAX_EDGES    (MAXE),
        .GOOD_WINDOWS (GOOD)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .ref_clk_in (ref_clk_in),
        .enable     (enable),
        .meas_valid (meas_valid),
        .edge_count (edge_count),
        .osc_ok     (osc_ok),
        .osc_fail   (osc_fail)
    );

    typedef struct {
        time t_meas;
        int  len;
    } win_t;

    win_t exp_q[$];
    time  rise_log[$];
    int   ref_half = 0;
    int   checks = 0;
    int   fails = 0;
    int   streak = 0;
    bit   mdl_fail = 1'b0;
    int   last_n = 0;
    bit   first_win = 1'b0;
    int   periods[6] = '{10, 10, 10, 8, 2, 0};

    always #(TCLK / 2) clk = ~clk;

    // Reference oscillator: period in clk cycles set by the stimulus, phase offset keeps edges off clk edges.
    initial begin : ref_gen
        #($urandom_range(1, 9));
        forever begin
            if (ref_half == 0) begin
                ref_clk_in = 1'b0;
                #10;
            end else begin
                ref_clk_in = 1'b1;
                rise_log.push_back($time);
                #(ref_half);
                ref_clk_in = 1'b0;
                #(ref_half);
            end
        end
    end

    task automatic check(input string name, input longint act, input longint lo, input longint hi);
        checks++;
        if (act < lo || act > hi) begin
            fails++;
            $display("FAIL %s at %0t: got %0d, expected %0d..%0d", name, $time, act, lo, hi);
        end
    endtask

    function automatic int edges_in(input time lo, input time hi);
        int n = 0;
        foreach (rise_log[i]) begin
            if (rise_log[i] > lo && rise_log[i] <= hi) n++;
        end
        return n;
    endfunction

    // Monitor: every meas_valid pops one expected window and checks timing, count and status.
    initial begin : monitor
        win_t w;
        time  t_now;
        int   n;
        int   nsat;
        int   lo;
        int   hi;
        forever begin
            @(negedge clk);
            if (meas_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_meas_valid", 1, 0, 0);
                end else begin
                    w = exp_q.pop_front();
                    t_now = $time;
                    check("meas_time", longint'(t_now), longint'(w.t_meas), longint'(w.t_meas));
                    n    = edges_in(t_now - 50 - time'(w.len * TCLK), t_now - 50);
                    nsat = (n > 255) ? 255 : n;
                    lo   = (n - 1 > 255) ? 255 : ((n - 1 < 0) ? 0 : n - 1);
                    hi   = (n + 1 > 255) ? 255 : n + 1;
                    check("edge_count", edge_count, lo, hi);
                    if (nsat >= MINE && nsat <= MAXE) begin
                        streak++;
                    end else begin
                        streak   = 0;
                        mdl_fail = 1'b1;
                    end
                    last_n = nsat;
                    @(negedge clk);
                    check("meas_pulse_width", meas_valid, 0, 0);
                    check("osc_ok", osc_ok, (streak >= GOOD) ? 1 : 0, (streak >= GOOD) ? 1 : 0);
                    check("osc_fail", osc_fail, mdl_fail, mdl_fail);
                end
            end
        end
    end

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One window starting at the current negedge; abort_at>0 drops enable that many cycles in.
    task automatic run_window(input int period, input int abort_at);
        win_t w;
        int   lo;
        int   hi;
        ref_half = period * (TCLK / 2);
        if (abort_at == 0) begin
            w.t_meas = $time + time'((WIN + 1) * TCLK);
            w.len    = first_win ? WIN : WIN + 1;
            exp_q.push_back(w);
            first_win = 1'b0;
            wait_neg(WIN + 1);
        end else begin
            wait_neg(abort_at);
            enable   = 1'b0;
            streak   = 0;
            mdl_fail = 1'b0;
            wait_neg(1);
            lo = (last_n > 0) ? last_n - 1 : 0;
            hi = (last_n < 255) ? last_n + 1 : 255;
            check("abort_osc_ok", osc_ok, 0, 0);
            check("abort_osc_fail", osc_fail, 0, 0);
            check("abort_meas_valid", meas_valid, 0, 0);
            check("abort_edge_count_hold", edge_count, lo, hi);
            wait_neg(5);
            enable    = 1'b1;
            first_win = 1'b1;
        end
    endtask

    task automatic reset_pulse(input int at);
        wait_neg(at);
        #3;
        rstn = 1'b0;
        #1;
        check("rst_meas_valid", meas_valid, 0, 0);
        check("rst_edge_count", edge_count, 0, 0);
        check("rst_osc_ok", osc_ok, 0, 0);
        check("rst_osc_fail", osc_fail, 0, 0);
        streak   = 0;
        mdl_fail = 1'b0;
        last_n   = 0;
        enable   = 1'b0;
        wait_neg(4);
        rstn      = 1'b1;
        enable    = 1'b1;
        first_win = 1'b1;
    endtask

    initial begin : stimulus
        int p;
        wait_neg(3);
        check("init_meas_valid", meas_valid, 0, 0);
        check("init_edge_count", edge_count, 0, 0);
        check("init_osc_ok", osc_ok, 0, 0);
        check("init_osc_fail", osc_fail, 0, 0);
        ref_half = 10 * (TCLK / 2);
        wait_neg(2);
        rstn      = 1'b1;
        enable    = 1'b1;
        first_win = 1'b1;

        repeat (5) run_window(10, 0);
        run_window(0, 0);
        repeat (2) run_window(10, 0);
        run_window(10, WIN / 2);
        repeat (4) run_window(10, 0);
        repeat (2) run_window(8, 0);
        run_window(2, 0);
        reset_pulse(WIN * 2 / 5);
        repeat (5) run_window(10, 0);

        repeat (12) begin
            p = periods[$urandom_range(0, 5)];
            if ($urandom_range(0, 5) == 0) run_window(p, $urandom_range(3, WIN - 5));
            else run_window(p, 0);
        end

        wait_neg(3);
        check("queue_drained", exp_q.size(), 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin : watchdog
        #(3_000_000);
        $display("FAIL watchdog: simulation exceeded time limit, got timeout, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", checks + 1, fails + 1);
        $fatal(1);
    end

endmodule

// File: doc/osc_clk_monitor.md
OSC_CLK_MONITOR -- requirements
Module: osc_clk_monitor

Interface
REQ-001 SHALL have parameter WIN_CYCLES, default 5000, measurement window length in clk cycles (range 16..65535).
REQ-002 SHALL have parameter MIN_EDGES, default 90, lowest in-range ref edge count per window.
REQ-003 SHALL have parameter MAX_EDGES, default 110, highest in-range ref edge count per window.
REQ-004 SHALL have parameter GOOD_WINDOWS, default 4, consecutive in-range windows needed before osc_ok (range 1..15).
REQ-005 SHALL have port: clk  input  1  fabric clock, the 25/50 MHz RC oscillator output (50 MHz nominal).
REQ-006 SHALL have port: rstn  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port: ref_clk_in  input  1  1 MHz RC oscillator clock, asynchronous to clk.
REQ-008 SHALL have port: enable  input  1  monitor run request.
REQ-009 SHALL have port: meas_valid  output  1  one-cycle pulse when a window completes.
REQ-010 SHALL have port: edge_count  output  8  ref rising-edge count of the last completed window.
REQ-011 SHALL have port: osc_ok  output  1  both oscillators verified in ratio.
REQ-012 SHALL have port: osc_fail  output  1  sticky out-of-range flag.

Function
REQ-013 ref_clk_in SHALL pass through a 2-flop synchronizer plus one history flop; a rising edge is detected when sync=1 and history=0 (3-cycle detect latency).
REQ-014 The FSM SHALL have states IDLE, MEASURE, CHECK.
REQ-015 IDLE: window and edge counters held at 0. IDLE->MEASURE when enable=1.
REQ-016 MEASURE: window counter increments every cycle. Edge counter increments per detected edge and saturates at 255. MEASURE->CHECK when the window counter reaches WIN_CYCLES-1.
REQ-017 CHECK: lasts exactly one cycle. meas_valid=1 and edge_count is loaded. Window and edge counters clear. CHECK->MEASURE if enable=1, else IDLE.
REQ-018 An edge detected on the CHECK cycle SHALL count toward the next window.
REQ-019 In-range means MIN_EDGES <= count <= MAX_EDGES, compared on the saturated 8-bit count.
REQ-020 A good-window counter (4 bit) SHALL increment on in-range CHECK, saturating at GOOD_WINDOWS, and clear on out-of-range CHECK.
REQ-021 osc_ok SHALL be registered high the cycle after the CHECK that brings the good-window counter to GOOD_WINDOWS. It SHALL go low the cycle after any out-of-range CHECK.
REQ-022 osc_fail SHALL be set the cycle after any out-of-range CHECK. It is cleared only by enable=0 or reset; a later good window does not clear it.
REQ-023 enable=0 in any state SHALL go to IDLE next cycle. It clears the window/edge/good counters, osc_ok and osc_fail. No meas_valid is produced and edge_count holds its last value.
REQ-024 Synchronizer flops SHALL run regardless of enable.

Reset
REQ-025 rstn low SHALL asynchronously force: state=IDLE, all counters=0, synchronizer/history=0, meas_valid=0, edge_count=0, osc_ok=0, osc_fail=0.
REQ-026 Reset release SHALL be synchronous to clk. The FSM SHALL leave IDLE no earlier than the first clk edge after rstn deasserts with enable=1.

Structure
REQ-027 Package osc_mon_pkg SHALL hold the FSM state enum and the default WIN_CYCLES/MIN_EDGES/MAX_EDGES/GOOD_WINDOWS constants.
REQ-028 The 2-flop synchronizer SHALL be the sole sub-module, osc_mon_sync (async active-low reset, reset value 0).
REQ-029 The window counter SHALL be 16 bit, the edge counter 8 bit saturating, the good-window counter 4 bit.

Verification
REQ-030 clk 50 MHz, ref 1 MHz, enable=1 from reset -> meas_valid every 5001 cycles with edge_count=100 (±1); osc_ok rises 1 cycle after the 4th meas_valid; osc_fail stays 0.
REQ-031 ref held at 0 after lock -> next meas_valid has edge_count=0; osc_ok falls and osc_fail rises 1 cycle later; osc_fail stays 1 after ref resumes.
REQ-032 ref 1.25 MHz -> edge_count=125 each window; osc_ok never asserts; osc_fail=1 after the first window.
REQ-033 ref 25 MHz -> edge_count saturates at 255 and osc_fail asserts.
REQ-034 enable dropped mid-window (cycle 2500) then re-raised -> no meas_valid for the aborted window; osc_ok/osc_fail=0; the next full window restarts the count at 0 and reports 100.
REQ-035 rstn pulsed low mid-window -> all outputs 0 immediately (asynchronous); after release, lock is reached again after 4 windows.
